lives_draw: RTL and testbench
=============================

# lives_draw

Reads the 29x31 heart icon ROM and overlays a row of heart icons, one per remaining life, onto the VGA pixel stream. Owns the player's lives counter. Sits in the ship/HUD chain between the timing generator or previous draw stage and the next draw stage or VGA output. Drives the ROM address and consumes the ROM colour one clock later.

## Interface
- `XPOS`, default 16: left pixel column of heart 0.
- `YPOS`, default 8: top pixel row of all hearts.
- `MAX_LIVES`, default 3: reset value and saturation limit of the lives count, range 1..7.
- `GAP`, default 4: horizontal pixels between adjacent hearts.
- `clk`, in, 1: pixel clock.
- `rst`, in, 1: synchronous reset, active-high.
- `hcount_in`, `vcount_in`, in, 11 each: current pixel coordinates.
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in`, in, 1 each: VGA timing.
- `rgb_in`, in, 12: upstream pixel colour.
- `hcount_out`, `vcount_out`, `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out`, out, same widths: inputs delayed by 3 clocks.
- `rgb_out`, out, 12: composited pixel.
- `rom_addr`, out, 10: ROM address `{y[4:0], x[4:0]}`.
- `rom_rgb`, in, 12: ROM data, valid 1 clock after `rom_addr`.
- `life_lost`, in, 1: single-cycle pulse that decrements lives.
- `life_gain`, in, 1: single-cycle pulse that increments lives.
- `lives`, out, 3: current lives count.
- `game_over`, out, 1: high while `lives == 0`.

## Operation
- **Lives counter**
  - `life_lost` alone: decrement, saturating at 0.
  - `life_gain` alone: increment, saturating at `MAX_LIVES`.
  - Both pulses in the same cycle: no change.
  - `game_over` is a registered `lives == 0`.
- **Displayed count**
  - `shown` is a separate register loaded from `lives` only in the cycle where `hcount_in == 0` and `vcount_in == 0`.
  - A mid-frame change therefore appears from the next frame on, with no tearing.
- **Stage 1 (registered)**
  - `rel_y = vcount_in - YPOS`.
  - For each i < `MAX_LIVES`: heart i spans `hcount_in` in [XPOS + i*(29+GAP), XPOS + i*(29+GAP) + 28].
  - Hit requires `rel_y` < 31 and i < `shown`.
  - On a hit: `rom_addr = {rel_y[4:0], rel_x_i[4:0]}`, and `hit_d1` = 1.
  - Otherwise: `rom_addr` holds its value and `hit_d1` = 0.
  - At most one i hits; the window comparators are unrolled in a for-loop.
- **Stage 2 (registered)**
  - `hit_d2 <= hit_d1`.
  - The ROM returns `rom_rgb` during this cycle.
- **Stage 3 (registered), `rgb_out` priority**
  1. `hblnk_d2 | vblnk_d2`: 12'h000.
  2. `hit_d2` with the pixel not transparent (see Configuration): `rom_rgb`.
  3. Otherwise: `rgb_in` delayed by 2 clocks.
- **Underflow**: subtractions are 11-bit unsigned. Wrap-around on underflow yields large values that fail the window compare, so no pixels are drawn left of or above the icon origin.

## Timing
- Reset values:
  - `rgb_out`, `rom_addr`, all `*_out` timing signals, `hit_d*`: 0.
  - `lives` and `shown`: `MAX_LIVES`.
  - `game_over`: 0.
- Reset mid-frame: the pipeline flushes to zeros and output resumes in step with the input after 3 clocks.
- Pixel-path latency: 3 clocks from any input to the matching `*_out` and `rgb_out`.
- `rom_addr` is presented 1 clock after its coordinates.
- ROM read latency is exactly 1 clock and is not stallable; there is no handshake.
- `lives` changes 1 clock after a pulse; `game_over` updates 1 clock after `lives`.
- Pulses landing in the same cycle as the frame-start load: `shown` takes the pre-update `lives`.

## Configuration
- `LIVES_TRANSPARENCY_EN`:
  - Defined: a hit pixel whose `rom_rgb == LIVES_KEY_RGB` (12'h000) passes the delayed `rgb_in` through, so hearts are drawn without their background box.
  - Undefined: every hit pixel shows `rom_rgb`, including the black 29x31 box.

## Structure
- Shared package `hud_pkg`:
  - Constants `HEART_W = 29`, `HEART_H = 31`, `LIVES_KEY_RGB = 12'h000`, `ROM_AW = 10`.
  - Typedef `vga_bus_t` bundling hcount, vcount, syncs and blanks.
- Sub-module `vga_delay`: parameterised N-stage register pipe, N = 3 here, synchronous `rst` clearing to 0. It delays the timing bus; a 2-stage instance delays `rgb_in`.
- ROM instance lives outside this block, at the top level.

## Test plan
- **Reset and lives counter:** reset, then `life_lost` x2 → `lives` 3→2→1; one more → 0 and `game_over` = 1 the cycle after; a further `life_lost` → stays 0.
- **Saturation and simultaneous pulses:** at `lives` = 3, `life_gain` → stays 3; `life_gain` and `life_lost` together at `lives` = 2 → stays 2.
- **Addressing and compositing:** `shown` = 3, pixel (hcount = 16+33+5, vcount = 8+7) → `rom_addr` = {5'd7, 5'd5} one clock later; `rgb_out` = `rom_rgb` 3 clocks after the input; model ROM returns 12'hF00 → `rgb_out` = 12'hF00.
- **Shown count and frame-start latch:** `shown` = 1, pixel in heart 1 → `rgb_out` = delayed `rgb_in`; `life_lost` mid-frame → heart still drawn until the frame-start cycle, gone in the next frame.
- **Transparency:** `LIVES_TRANSPARENCY_EN` defined, `rom_rgb` = 12'h000, `rgb_in` = 12'h0AF → `rgb_out` = 12'h0AF; undefined → 12'h000.
- **Pipeline alignment and blanking:** `hblnk_in` pulse and a `hsync_in` edge appear at the outputs exactly 3 clocks later; `rgb_out` = 0 while the delayed blank is high, even inside a heart window.

Source files
------------

// File: rtl/hud_pkg.sv
// Shared HUD constants and the VGA timing bundle used by the draw stages.
package hud_pkg;

  localparam int          HEART_W       = 29;
  localparam int          HEART_H       = 31;
  localparam logic [11:0] LIVES_KEY_RGB = 12'h000;
  localparam int          ROM_AW        = 10;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } vga_bus_t;

endpackage

// File: rtl/lives_draw_if.sv
// Pixel stream, heart ROM port and lives controls of lives_draw, bundled.
// No valid/ready: every signal moves one step per pixel clock at a fixed latency.
interface lives_draw_if;
  import hud_pkg::*;

  logic [10:0]       hcount_in;
  logic [10:0]       vcount_in;
  logic              hsync_in;
  logic              vsync_in;
  logic              hblnk_in;
  logic              vblnk_in;
  logic [11:0]       rgb_in;
  logic [10:0]       hcount_out;
  logic [10:0]       vcount_out;
  logic              hsync_out;
  logic              vsync_out;
  logic              hblnk_out;
  logic              vblnk_out;
  logic [11:0]       rgb_out;
  logic [ROM_AW-1:0] rom_addr;
  logic [11:0]       rom_rgb;
  logic              life_lost;
  logic              life_gain;
  logic [2:0]        lives;
  logic              game_over;

  // Upstream / environment side.
  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
    output rom_rgb, life_lost, life_gain,
    input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
    input  rgb_out, rom_addr, lives, game_over
  );

  // The draw stage itself.
  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
    input  rom_rgb, life_lost, life_gain,
    output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
    output rgb_out, rom_addr, lives, game_over
  );

endinterface

// File: rtl/lives_draw_vga_delay.sv
// vga_delay: N-stage register pipe of width W, synchronously cleared to zero.
module vga_delay #(
  parameter int W = 1,
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[N-1];

endmodule

// File: rtl/lives_draw.sv
// Lives counter plus heart-row overlay on the VGA stream (3-clock pixel latency).
// Optional macro LIVES_TRANSPARENCY_EN keys out the icon's black background.
module lives_draw
  import hud_pkg::*;
#(
  parameter int XPOS      = 16,
  parameter int YPOS      = 8,
  parameter int MAX_LIVES = 3,
  parameter int GAP       = 4
) (
  input logic         clk,
  input logic         rst,
  lives_draw_if.slave bus
);

  logic [2:0]        lives_q, lives_d;
  logic [2:0]        shown_q, shown_d;
  logic              game_over_q;
  logic              frame_start;

  logic [10:0]       rel_y, rel_x;
  logic              hit_d1_q, hit_d1_d;
  logic              hit_d2_q;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;

  vga_bus_t          bus_in, bus_d3;
  logic [11:0]       rgb_d2;
  logic [1:0]        blnk_d2;
  logic              draw;
  logic [11:0]       rgb_out_q, rgb_out_d;

  // ---------------- lives counter and per-frame snapshot ----------------
  always_comb begin
    lives_d = lives_q;
    if (bus.life_lost && !bus.life_gain && lives_q != 3'd0)
      lives_d = lives_q - 3'd1;
    else if (bus.life_gain && !bus.life_lost && lives_q < 3'(MAX_LIVES))
      lives_d = lives_q + 3'd1;
  end

  // Snapshot at the first pixel so a frame never shows a half-updated row.
  assign frame_start = (bus.hcount_in == 11'd0) && (bus.vcount_in == 11'd0);
  assign shown_d     = frame_start ? lives_q : shown_q;

  // ---------------- stage 1: window compare and ROM address ----------------
  // Unsigned wrap puts pixels left of / above a heart far out of range.
  always_comb begin
    rel_y      = bus.vcount_in - 11'(YPOS);
    rel_x      = '0;
    hit_d1_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    for (int i = 0; i < MAX_LIVES; i++) begin
      rel_x = bus.hcount_in - 11'(XPOS + i * (HEART_W + GAP));
      if (rel_x < 11'(HEART_W) && rel_y < 11'(HEART_H) && i < int'(shown_q)) begin
        hit_d1_d   = 1'b1;
        rom_addr_d = {rel_y[4:0], rel_x[4:0]};
      end
    end
  end

  // ---------------- stage 3: compositing ----------------
`ifdef LIVES_TRANSPARENCY_EN
  assign draw = hit_d2_q && (bus.rom_rgb != LIVES_KEY_RGB);
`else
  assign draw = hit_d2_q;
`endif

  always_comb begin
    rgb_out_d = rgb_d2;
    if (blnk_d2[1] | blnk_d2[0]) rgb_out_d = 12'h000;
    else if (draw)               rgb_out_d = bus.rom_rgb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lives_q     <= 3'(MAX_LIVES);
      shown_q     <= 3'(MAX_LIVES);
      game_over_q <= 1'b0;
      hit_d1_q    <= 1'b0;
      hit_d2_q    <= 1'b0;
      rom_addr_q  <= '0;
      rgb_out_q   <= '0;
    end else begin
      lives_q     <= lives_d;
      shown_q     <= shown_d;
      game_over_q <= (lives_q == 3'd0);
      hit_d1_q    <= hit_d1_d;
      hit_d2_q    <= hit_d1_q;
      rom_addr_q  <= rom_addr_d;
      rgb_out_q   <= rgb_out_d;
    end
  end

  // ---------------- timing delay lines ----------------
  assign bus_in = '{hcount: bus.hcount_in, vcount: bus.vcount_in,
                    hsync:  bus.hsync_in,  vsync:  bus.vsync_in,
                    hblnk:  bus.hblnk_in,  vblnk:  bus.vblnk_in};

  vga_delay #(.W($bits(vga_bus_t)), .N(3)) u_bus_dly (
    .clk (clk),
    .rst (rst),
    .d_i (bus_in),
    .q_o (bus_d3)
  );

  vga_delay #(.W(12), .N(2)) u_rgb_dly (
    .clk (clk),
    .rst (rst),
    .d_i (bus.rgb_in),
    .q_o (rgb_d2)
  );

  // Blanks are needed one stage early to force black into the stage-3 register.
  vga_delay #(.W(2), .N(2)) u_blnk_dly (
    .clk (clk),
    .rst (rst),
    .d_i ({bus.hblnk_in, bus.vblnk_in}),
    .q_o (blnk_d2)
  );

  assign bus.hcount_out = bus_d3.hcount;
  assign bus.vcount_out = bus_d3.vcount;
  assign bus.hsync_out  = bus_d3.hsync;
  assign bus.vsync_out  = bus_d3.vsync;
  assign bus.hblnk_out  = bus_d3.hblnk;
  assign bus.vblnk_out  = bus_d3.vblnk;
  assign bus.rgb_out    = rgb_out_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.lives      = lives_q;
  assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_lives_draw.sv
// Directed bench for lives_draw: lives counter, addressing, frame latch, blanking.
module tb_lives_draw;

  logic        clk;
  logic        rst;
  logic [11:0] rom_color;
  int          total;
  int          bad;

  lives_draw_if bus ();

  lives_draw #(.XPOS(16), .YPOS(8), .MAX_LIVES(3), .GAP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous heart ROM model: constant colour, 1-clock read latency.
  always @(posedge clk) bus.rom_rgb <= rom_color;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_px(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb);
    bus.hcount_in = h;
    bus.vcount_in = v;
    bus.rgb_in    = rgb;
  endtask

  task automatic idle_px();
    set_px(11'd1000, 11'd600, 12'h123);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_px();
    bus.hsync_in  = 1'b0;
    bus.vsync_in  = 1'b0;
    bus.hblnk_in  = 1'b0;
    bus.vblnk_in  = 1'b0;
    bus.life_lost = 1'b0;
    bus.life_gain = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse(input logic lost, input logic gain);
    bus.life_lost = lost;
    bus.life_gain = gain;
    tick();
    bus.life_lost = 1'b0;
    bus.life_gain = 1'b0;
  endtask

  task automatic frame_start();
    set_px(11'd0, 11'd0, 12'h123);
    tick();
    idle_px();
  endtask

  // One pixel, then idle; returns rom_addr 1 clock and rgb_out 3 clocks later.
  task automatic run_px(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                        output logic [9:0] addr_seen, output logic [11:0] rgb_seen);
    set_px(h, v, rgb);
    tick();
    addr_seen = bus.rom_addr;
    idle_px();
    tick();
    tick();
    rgb_seen = bus.rgb_out;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    total++; if (bus.lives !== 3'd3) begin bad++; $display("FAIL reset_lives: got %0d want 3", bus.lives); end
    total++; if (bus.game_over !== 1'b0) begin bad++; $display("FAIL reset_game_over: got %b want 0", bus.game_over); end
    total++; if (bus.rgb_out !== 12'h000) begin bad++; $display("FAIL reset_rgb: got %h want 000", bus.rgb_out); end
    total++; if (bus.rom_addr !== 10'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", bus.rom_addr); end
    total++; if (bus.hcount_out !== 11'd0 || bus.hblnk_out !== 1'b0) begin
      bad++; $display("FAIL reset_timing: got h=%0d hb=%b want 0/0", bus.hcount_out, bus.hblnk_out);
    end
  endtask

  task automatic test_lives();
    apply_reset();
    pulse(1'b1, 1'b0);
    total++; if (bus.lives !== 3'd2) begin bad++; $display("FAIL lost_1: got %0d want 2", bus.lives); end
    pulse(1'b1, 1'b0);
    total++; if (bus.lives !== 3'd1) begin bad++; $display("FAIL lost_2: got %0d want 1", bus.lives); end
    pulse(1'b1, 1'b0);
    total++; if (bus.lives !== 3'd0) begin bad++; $display("FAIL lost_3: got %0d want 0", bus.lives); end
    total++; if (bus.game_over !== 1'b0) begin bad++; $display("FAIL game_over_lag: got %b want 0", bus.game_over); end
    tick();
    total++; if (bus.game_over !== 1'b1) begin bad++; $display("FAIL game_over_set: got %b want 1", bus.game_over); end
    pulse(1'b1, 1'b0);
    total++; if (bus.lives !== 3'd0) begin bad++; $display("FAIL lost_floor: got %0d want 0", bus.lives); end
    pulse(1'b0, 1'b1);
    total++; if (bus.lives !== 3'd1) begin bad++; $display("FAIL gain_from_0: got %0d want 1", bus.lives); end
    tick();
    total++; if (bus.game_over !== 1'b0) begin bad++; $display("FAIL game_over_clr: got %b want 0", bus.game_over); end
  endtask

  task automatic test_saturation();
    apply_reset();
    pulse(1'b0, 1'b1);
    total++; if (bus.lives !== 3'd3) begin bad++; $display("FAIL gain_ceiling: got %0d want 3", bus.lives); end
    pulse(1'b1, 1'b0);
    total++; if (bus.lives !== 3'd2) begin bad++; $display("FAIL lost_to_2: got %0d want 2", bus.lives); end
    pulse(1'b1, 1'b1);
    total++; if (bus.lives !== 3'd2) begin bad++; $display("FAIL both_pulses: got %0d want 2", bus.lives); end
  endtask

  task automatic test_addressing();
    // pixel, expected address (held on a miss) and hit flag, all with 3 hearts shown
    int th [11] = '{54, 16, 44, 45, 10, 20, 20, 82, 110, 111, 115};
    int tv [11] = '{15,  8, 38, 15, 15,  5, 39,  8,  20,  20,  10};
    int ta [11] = '{229, 0, 988, 988, 988, 988, 988, 0, 412, 412, 412};
    int tk [11] = '{1,   1,   1,   0,   0,   0,   0, 1,   1,   0,   0};
    logic [9:0]  a;
    logic [11:0] c;
    logic [11:0] exp_c;
    apply_reset();
    rom_color = 12'hF00;
    for (int k = 0; k < 11; k++) begin
      run_px(11'(th[k]), 11'(tv[k]), 12'h456, a, c);
      exp_c = (tk[k] != 0) ? 12'hF00 : 12'h456;
      total++; if (a !== 10'(ta[k])) begin
        bad++; $display("FAIL addr_%0d_%0d: got %0d want %0d", th[k], tv[k], a, ta[k]);
      end
      total++; if (c !== exp_c) begin
        bad++; $display("FAIL rgb_%0d_%0d: got %h want %h", th[k], tv[k], c, exp_c);
      end
    end
  endtask

  task automatic test_shown_latch();
    logic [9:0]  a;
    logic [11:0] c;
    apply_reset();
    rom_color = 12'hF00;
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    frame_start();
    run_px(11'd54, 11'd15, 12'h0F0, a, c);
    total++; if (c !== 12'h0F0) begin bad++; $display("FAIL shown1_heart1: got %h want 0f0", c); end
    run_px(11'd20, 11'd10, 12'h0F0, a, c);
    total++; if (c !== 12'hF00) begin bad++; $display("FAIL shown1_heart0: got %h want f00", c); end
    pulse(1'b0, 1'b1);
    run_px(11'd54, 11'd15, 12'h0F0, a, c);
    total++; if (c !== 12'h0F0) begin bad++; $display("FAIL midframe_gain: got %h want 0f0", c); end
    // frame start coinciding with a loss latches the pre-update count (2)
    set_px(11'd0, 11'd0, 12'h123);
    bus.life_lost = 1'b1;
    tick();
    bus.life_lost = 1'b0;
    idle_px();
    total++; if (bus.lives !== 3'd1) begin bad++; $display("FAIL fs_pulse_lives: got %0d want 1", bus.lives); end
    run_px(11'd54, 11'd15, 12'h0F0, a, c);
    total++; if (c !== 12'hF00) begin bad++; $display("FAIL fs_pre_update: got %h want f00", c); end
    frame_start();
    run_px(11'd54, 11'd15, 12'h0F0, a, c);
    total++; if (c !== 12'h0F0) begin bad++; $display("FAIL next_frame_gone: got %h want 0f0", c); end
  endtask

  task automatic test_transparency();
    logic [9:0]  a;
    logic [11:0] c;
    logic [11:0] exp_c;
    apply_reset();
    rom_color = 12'h000;
`ifdef LIVES_TRANSPARENCY_EN
    exp_c = 12'h0AF;
`else
    exp_c = 12'h000;
`endif
    run_px(11'd20, 11'd10, 12'h0AF, a, c);
    total++; if (c !== exp_c) begin bad++; $display("FAIL key_pixel: got %h want %h", c, exp_c); end
    rom_color = 12'hF00;
  endtask

  task automatic test_pipeline_blank();
    apply_reset();
    rom_color = 12'hF00;
    set_px(11'd20, 11'd10, 12'h0F0);
    bus.hblnk_in = 1'b1;
    bus.hsync_in = 1'b1;
    tick();
    bus.hblnk_in = 1'b0;
    idle_px();
    total++; if (bus.hblnk_out !== 1'b0 || bus.hsync_out !== 1'b0) begin
      bad++; $display("FAIL align_clk1: got hb=%b hs=%b want 0/0", bus.hblnk_out, bus.hsync_out);
    end
    tick();
    total++; if (bus.hblnk_out !== 1'b0 || bus.hsync_out !== 1'b0) begin
      bad++; $display("FAIL align_clk2: got hb=%b hs=%b want 0/0", bus.hblnk_out, bus.hsync_out);
    end
    tick();
    total++; if (bus.hblnk_out !== 1'b1 || bus.hsync_out !== 1'b1) begin
      bad++; $display("FAIL align_clk3: got hb=%b hs=%b want 1/1", bus.hblnk_out, bus.hsync_out);
    end
    total++; if (bus.hcount_out !== 11'd20 || bus.vcount_out !== 11'd10) begin
      bad++; $display("FAIL align_coords: got %0d,%0d want 20,10", bus.hcount_out, bus.vcount_out);
    end
    total++; if (bus.rgb_out !== 12'h000) begin bad++; $display("FAIL blank_in_heart: got %h want 000", bus.rgb_out); end
    tick();
    total++; if (bus.hblnk_out !== 1'b0 || bus.hsync_out !== 1'b1) begin
      bad++; $display("FAIL align_clk4: got hb=%b hs=%b want 0/1", bus.hblnk_out, bus.hsync_out);
    end
    total++; if (bus.rgb_out !== 12'h123) begin bad++; $display("FAIL after_blank: got %h want 123", bus.rgb_out); end
    // vertical blank also forces black
    set_px(11'd20, 11'd10, 12'h0F0);
    bus.vblnk_in = 1'b1;
    tick();
    bus.vblnk_in = 1'b0;
    idle_px();
    tick();
    tick();
    total++; if (bus.vblnk_out !== 1'b1 || bus.rgb_out !== 12'h000) begin
      bad++; $display("FAIL vblank: got vb=%b rgb=%h want 1/000", bus.vblnk_out, bus.rgb_out);
    end
    bus.hsync_in = 1'b0;
  endtask

  task automatic test_midframe_reset();
    logic [9:0]  a;
    logic [11:0] c;
    apply_reset();
    pulse(1'b1, 1'b0);
    set_px(11'd20, 11'd10, 12'h0F0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_px();
    total++; if (bus.rom_addr !== 10'd0 || bus.rgb_out !== 12'h000 || bus.hcount_out !== 11'd0) begin
      bad++; $display("FAIL midreset_flush: got a=%0d rgb=%h h=%0d want 0/000/0", bus.rom_addr, bus.rgb_out, bus.hcount_out);
    end
    total++; if (bus.lives !== 3'd3) begin bad++; $display("FAIL midreset_lives: got %0d want 3", bus.lives); end
    run_px(11'd82, 11'd8, 12'h0F0, a, c);
    total++; if (c !== 12'hF00 || a !== 10'd0) begin
      bad++; $display("FAIL midreset_resume: got a=%0d rgb=%h want 0/f00", a, c);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total     = 0;
    bad       = 0;
    rom_color = 12'hF00;
    test_reset();
    test_lives();
    test_saturation();
    test_addressing();
    test_shown_latch();
    test_transparency();
    test_pipeline_blank();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
